// File: rtl/mips8_defs.sv
// ---------------------------------------------------------------------------
// mips8_defs
// Shared definitions for the 8-bit pipelined MIPS core: opcode constants,
// 24-bit instruction field positions, fetch-controller state encodings and
// small field-extraction helpers. PC_IM, the decoder and the fetch hazard
// controller all import this package.
// ---------------------------------------------------------------------------
package mips8_defs;

    localparam int INS_W = 24;

    // Instruction field bit positions
    localparam int OPC_HI = 23;
    localparam int OPC_LO = 19;
    localparam int RD_HI  = 18;
    localparam int RD_LO  = 16;
    localparam int RS1_HI = 15;
    localparam int RS1_LO = 13;
    localparam int RS2_HI = 12;
    localparam int RS2_LO = 10;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    // Opcodes with special meaning to the fetch stage
    localparam logic [4:0] OPC_NOP  = 5'b00000;
    localparam logic [4:0] OPC_LOAD = 5'b10100;
    localparam logic [4:0] OPC_JMP  = 5'b11000;
    localparam logic [4:0] OPC_HALT = 5'b11111;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    function automatic logic [4:0] ins_opcode(input logic [INS_W-1:0] ins);
        return ins[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [2:0] ins_rd(input logic [INS_W-1:0] ins);
        return ins[RD_HI:RD_LO];
    endfunction

    function automatic logic [2:0] ins_rs1(input logic [INS_W-1:0] ins);
        return ins[RS1_HI:RS1_LO];
    endfunction

    function automatic logic [2:0] ins_rs2(input logic [INS_W-1:0] ins);
        return ins[RS2_HI:RS2_LO];
    endfunction

    function automatic logic [7:0] ins_imm(input logic [INS_W-1:0] ins);
        return ins[IMM_HI:IMM_LO];
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Combinational load-use check: flags a hazard when the previous issued
// instruction was a LOAD whose destination matches either source register
// of the instruction now in IF/ID. NOP, JMP and HALT read no registers.
//   prev_load  in  1  previous issued instruction was a LOAD
//   prev_rd    in  3  destination of that instruction
//   opcode     in  5  opcode of the current instruction
//   rs1, rs2   in  3  source register fields of the current instruction
//   hazard     out 1  1 = one bubble required
// ---------------------------------------------------------------------------
module hazard_detect
    import mips8_defs::*;
(
    input  logic       prev_load,
    input  logic [2:0] prev_rd,
    input  logic [4:0] opcode,
    input  logic [2:0] rs1,
    input  logic [2:0] rs2,
    output logic       hazard
);

    logic [2:0] src [2];
    logic [1:0] src_match;
    logic       uses_regs;

    assign src[0] = rs1;
    assign src[1] = rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
            assign src_match[gi] = (src[gi] == prev_rd);
        end
    endgenerate

    assign uses_regs = (opcode != OPC_NOP) && (opcode != OPC_JMP) &&
                       (opcode != OPC_HALT);

    assign hazard = prev_load && uses_regs && (|src_match);

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_hazard_ctrl
// Fetch-stage controller: sequences PC_IM from the instruction in IF/ID.
// Resolves unconditional jumps (one flushed slot), inserts a single bubble
// on load-use, stops fetch on HALT and honours a downstream freeze.
// Outputs are combinational (Mealy) from state, ins, ext_hold and the
// tracking registers.
//   clk          in  1   rising-edge clock
//   reset        in  1   synchronous active-high reset
//   ins          in  24  IF/ID instruction
//   ext_hold     in  1   downstream freeze request
//   Stall        out 1   PC_IM holds PC
//   Stall_pm     out 1   PC_IM holds its instruction register
//   pc_mux_sel   out 1   PC loads jmp_loc instead of PC+1
//   jmp_loc      out 8   jump target
//   issue_valid  out 1   ins advances into ID/EX (0 = bubble)
//   halted       out 1   HALTED state
//   stall_count  out 8   saturating count of Stall cycles
// ---------------------------------------------------------------------------
module fetch_hazard_ctrl
    import mips8_defs::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [INS_W-1:0] ins,
    input  logic             ext_hold,
    output logic             Stall,
    output logic             Stall_pm,
    output logic             pc_mux_sel,
    output logic [7:0]       jmp_loc,
    output logic             issue_valid,
    output logic             halted,
    output logic [7:0]       stall_count
);

    fetch_state_t state_reg, state_next;
    logic         prev_load_reg;
    logic [2:0]   prev_rd_reg;
    logic [7:0]   stall_count_reg;
    logic [4:0]   opcode;
    logic         load_use;

    assign opcode = ins_opcode(ins);

    hazard_detect u_hazard_detect (
        .prev_load (prev_load_reg),
        .prev_rd   (prev_rd_reg),
        .opcode    (opcode),
        .rs1       (ins_rs1(ins)),
        .rs2       (ins_rs2(ins)),
        .hazard    (load_use)
    );

    // Decision logic, highest priority first.
    always_comb begin
        Stall       = 1'b0;
        Stall_pm    = 1'b0;
        pc_mux_sel  = 1'b0;
        issue_valid = 1'b0;
        halted      = 1'b0;
        state_next  = state_reg;
        if (reset) begin
            state_next = ST_RUN;
        end else if (state_reg == ST_HALTED) begin
            Stall    = 1'b1;
            Stall_pm = 1'b1;
            halted   = 1'b1;
        end else if (ext_hold) begin
            // Freeze everything; a pending flush survives the hold.
            Stall    = 1'b1;
            Stall_pm = 1'b1;
        end else if (state_reg == ST_FLUSH) begin
            // Wrong-path fetch: dropped regardless of opcode.
            state_next = ST_RUN;
        end else if (load_use) begin
            Stall    = 1'b1;
            Stall_pm = 1'b1;
        end else if (opcode == OPC_JMP) begin
            pc_mux_sel = 1'b1;
            state_next = ST_FLUSH;
        end else if (opcode == OPC_HALT) begin
            Stall      = 1'b1;
            Stall_pm   = 1'b1;
            state_next = ST_HALTED;
        end else begin
            issue_valid = 1'b1;
        end
    end

    assign jmp_loc     = pc_mux_sel ? ins_imm(ins) : 8'h00;
    assign stall_count = stall_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_RUN;
            prev_load_reg   <= 1'b0;
            prev_rd_reg     <= 3'd0;
            stall_count_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            if (!ext_hold) begin
                // A bubble never forwards a load, so the stall lasts one cycle.
                prev_load_reg <= issue_valid && (opcode == OPC_LOAD);
                prev_rd_reg   <= ins_rd(ins);
            end
            if (Stall && (stall_count_reg != 8'hFF)) begin
                stall_count_reg <= stall_count_reg + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_hazard_ctrl
// Directed-vector bench for fetch_hazard_ctrl. Inputs change on the falling
// edge; outputs are compared 1 ns later, before the next rising edge.
// ctrl vector packing: {halted, issue_valid, pc_mux_sel, Stall_pm, Stall}.
// ---------------------------------------------------------------------------
module tb_fetch_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] ins;
    logic        ext_hold;
    logic        Stall, Stall_pm, pc_mux_sel, issue_valid, halted;
    logic [7:0]  jmp_loc, stall_count;

    int checks_cnt = 0;
    int errors_cnt = 0;

    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_LOAD = 5'b10100;
    localparam logic [4:0] OP_JMP  = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11111;

    // ctrl patterns {halted, issue_valid, pc_mux_sel, Stall_pm, Stall}
    localparam logic [4:0] C_IDLE  = 5'b00000;
    localparam logic [4:0] C_ISSUE = 5'b01000;
    localparam logic [4:0] C_STALL = 5'b00011;
    localparam logic [4:0] C_JUMP  = 5'b00100;
    localparam logic [4:0] C_HALTD = 5'b10011;

    always #5 clk = ~clk;

    fetch_hazard_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .ins         (ins),
        .ext_hold    (ext_hold),
        .Stall       (Stall),
        .Stall_pm    (Stall_pm),
        .pc_mux_sel  (pc_mux_sel),
        .jmp_loc     (jmp_loc),
        .issue_valid (issue_valid),
        .halted      (halted),
        .stall_count (stall_count)
    );

    function automatic logic [23:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic [7:0] imm);
        return {op, rd, rs1, rs2, 2'b00, imm};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus and compare the combinational outputs.
    task automatic step(input string tag, input logic rst, input logic hold,
                        input logic [23:0] ins_v, input logic [4:0] exp_ctrl,
                        input logic [7:0] exp_jmp, input logic [7:0] exp_cnt,
                        input bit show);
        @(negedge clk);
        reset    = rst;
        ext_hold = hold;
        ins      = ins_v;
        #1;
        check_val({tag, ".ctrl"}, {27'd0, halted, issue_valid, pc_mux_sel, Stall_pm, Stall},
                  {27'd0, exp_ctrl});
        check_val({tag, ".jmp_loc"}, {24'd0, jmp_loc}, {24'd0, exp_jmp});
        check_val({tag, ".stall_count"}, {24'd0, stall_count}, {24'd0, exp_cnt});
        if (show)
            $display("txn %-14s rst=%0b hold=%0b ins=%06h ctrl=%05b jmp=%02h cnt=%0d",
                     tag, rst, hold, ins_v, {halted, issue_valid, pc_mux_sel, Stall_pm, Stall},
                     jmp_loc, stall_count);
    endtask

    initial begin
        reset    = 1'b1;
        ext_hold = 1'b0;
        ins      = 24'h0;

        // Reset held two cycles; a JMP on ins must not leak through.
        step("rst0", 1, 0, mk(OP_JMP, 0, 0, 0, 8'h08), C_IDLE, 8'h00, 8'd0, 1);
        step("rst1", 1, 0, mk(OP_JMP, 0, 0, 0, 8'h08), C_IDLE, 8'h00, 8'd0, 1);
        step("first_issue", 0, 0, 24'h080000, C_ISSUE, 8'h00, 8'd0, 1);

        // Load-use on rs1: exactly one bubble.
        step("load_rd3", 0, 0, mk(OP_LOAD, 3, 0, 0, 0), C_ISSUE, 8'h00, 8'd0, 1);
        step("lu_rs1", 0, 0, mk(OP_ADD, 7, 3, 1, 0), C_STALL, 8'h00, 8'd0, 1);
        step("lu_rs1_go", 0, 0, mk(OP_ADD, 7, 3, 1, 0), C_ISSUE, 8'h00, 8'd1, 1);
        // No register match: no stall.
        step("load_rd3b", 0, 0, mk(OP_LOAD, 3, 0, 0, 0), C_ISSUE, 8'h00, 8'd1, 1);
        step("no_lu", 0, 0, mk(OP_ADD, 7, 4, 5, 0), C_ISSUE, 8'h00, 8'd1, 1);
        // Load-use on rs2.
        step("load_rd5", 0, 0, mk(OP_LOAD, 5, 0, 0, 0), C_ISSUE, 8'h00, 8'd1, 1);
        step("lu_rs2", 0, 0, mk(OP_ADD, 6, 1, 5, 0), C_STALL, 8'h00, 8'd1, 1);
        step("lu_rs2_go", 0, 0, mk(OP_ADD, 6, 1, 5, 0), C_ISSUE, 8'h00, 8'd2, 1);
        // NOP after load never stalls even though its fields match.
        step("load_rd0", 0, 0, mk(OP_LOAD, 0, 0, 0, 0), C_ISSUE, 8'h00, 8'd2, 1);
        step("nop_no_lu", 0, 0, mk(OP_NOP, 0, 0, 0, 0), C_ISSUE, 8'h00, 8'd2, 1);

        // JMP right after a load with matching rs1 field: jump, no stall.
        step("load_rd0b", 0, 0, mk(OP_LOAD, 0, 0, 0, 0), C_ISSUE, 8'h00, 8'd2, 1);
        step("jmp08", 0, 0, mk(OP_JMP, 0, 0, 0, 8'h08), C_JUMP, 8'h08, 8'd2, 1);
        // Wrong-path HALT in the flush slot is discarded.
        step("flush_halt", 0, 0, mk(OP_HALT, 0, 0, 0, 0), C_IDLE, 8'h00, 8'd2, 1);
        step("after_jmp", 0, 0, mk(OP_ADD, 1, 2, 2, 0), C_ISSUE, 8'h00, 8'd2, 1);

        // ext_hold for three cycles while a flush is pending.
        step("jmp20", 0, 0, mk(OP_JMP, 0, 0, 0, 8'h20), C_JUMP, 8'h20, 8'd2, 1);
        step("hold1", 0, 1, mk(OP_JMP, 0, 0, 0, 8'h44), C_STALL, 8'h00, 8'd2, 1);
        step("hold2", 0, 1, mk(OP_JMP, 0, 0, 0, 8'h44), C_STALL, 8'h00, 8'd3, 1);
        step("hold3", 0, 1, mk(OP_JMP, 0, 0, 0, 8'h44), C_STALL, 8'h00, 8'd4, 1);
        step("flush_jmp", 0, 0, mk(OP_JMP, 0, 0, 0, 8'h44), C_IDLE, 8'h00, 8'd5, 1);
        step("after_hold", 0, 0, mk(OP_ADD, 1, 2, 2, 0), C_ISSUE, 8'h00, 8'd5, 1);

        // Reset during a load-use stall.
        step("load_rd2", 0, 0, mk(OP_LOAD, 2, 0, 0, 0), C_ISSUE, 8'h00, 8'd5, 1);
        step("lu_pre_rst", 0, 0, mk(OP_ADD, 4, 2, 0, 0), C_STALL, 8'h00, 8'd5, 1);
        step("rst_in_stall", 1, 0, mk(OP_ADD, 4, 2, 0, 0), C_IDLE, 8'h00, 8'd6, 1);
        step("post_rst", 0, 0, mk(OP_ADD, 4, 2, 0, 0), C_ISSUE, 8'h00, 8'd0, 1);

        // HALT: decode cycle, then held for 300 cycles with saturation.
        step("halt_dec", 0, 0, mk(OP_HALT, 0, 0, 0, 0), C_STALL, 8'h00, 8'd0, 1);
        for (int i = 1; i <= 300; i++) begin
            step("halted", 0, (i % 7) == 0, mk(OP_ADD, 0, 0, 0, 0), C_HALTD, 8'h00,
                 (i > 255) ? 8'hFF : 8'(i), 0);
        end
        $display("txn halted_x300    halted=%0b cnt=%0d", halted, stall_count);
        step("halt_rst", 1, 0, mk(OP_ADD, 0, 0, 0, 0), C_IDLE, 8'h00, 8'hFF, 1);
        step("halt_exit", 0, 0, mk(OP_ADD, 0, 0, 0, 0), C_ISSUE, 8'h00, 8'd0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
